seq_cla_add_ctrl: RTL and testbench



---
 rtl/seq_cla_add_pkg.sv | 24 ++
 rtl/cla4_slice.sv | 28 ++
 rtl/seq_cla_add_ctrl.sv | 121 ++++++++++++
 tb/tb_seq_cla_add_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_cla_add_pkg.sv
// Shared types and sizing helpers for the sequential CLA adder controller.
// Optional subtract mode is enabled by defining SEQ_CLA_ADD_CTRL_SUB_EN.
package seq_cla_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nslice(input int width);
        return width / SLICE_W;
    endfunction

    // Index register never collapses to zero bits, even for a single slice.
    function automatic int calc_idx_w(input int width);
        int n;
        n = width / SLICE_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead adder slice (generate/propagate form).
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = x & y;
    assign p = x ^ y;

    assign c[0] = c0;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s  = p ^ c[3:0];
    assign c4 = c[4];

endmodule

// File: rtl/seq_cla_add_ctrl.sv
// Wide adder that walks one cla4_slice over the operands, one nibble per clock.
// Define SEQ_CLA_ADD_CTRL_SUB_EN to add the 'sub' port (a - b via ~b and carry-in 1).
module seq_cla_add_ctrl
    import seq_cla_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_CLA_ADD_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = calc_nslice(WIDTH);
    localparam int IDX_W  = calc_idx_w(WIDTH);

    // Handshake: a transfer happens only on an edge where valid and ready are
    // both high; in_valid is ignored outside IDLE, and a result is released
    // only on the out_valid/out_ready edge, never overlapping a new accept.

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [SLICE_W-1:0] x;
    logic [SLICE_W-1:0] y;
    logic [SLICE_W-1:0] s;
    logic               c4;

    always_comb begin
        x = '0;
        y = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx == IDX_W'(k)) begin
                x = a_q[k*SLICE_W +: SLICE_W];
                y = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    cla4_slice u_slice (
        .x  (x),
        .y  (y),
        .c0 (carry),
        .s  (s),
        .c4 (c4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
`ifdef SEQ_CLA_ADD_CTRL_SUB_EN
                        // Subtract as a + ~b + 1; cin is ignored in that mode.
                        b_q   <= sub ? ~b : b;
                        carry <= sub | cin;
`else
                        b_q   <= b;
                        carry <= cin;
`endif
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (idx == IDX_W'(k)) begin
                            sum[k*SLICE_W +: SLICE_W] <= s;
                        end
                    end
                    carry <= c4;
                    if (idx == IDX_W'(NSLICE - 1)) begin
                        cout      <= c4;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_cla_add_ctrl.sv
// Directed bench for seq_cla_add_ctrl (WIDTH=16) with an expected-result queue.
module tb_seq_cla_add_ctrl;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub_i     = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    logic [W:0] exp_q[$];

    seq_cla_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_CLA_ADD_CTRL_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one request; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input bit inject);
        logic [W:0] e;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = av; b = bv; cin = cv; sub_i = sv; in_valid = 1'b1;
        if (sv) e = {1'b0, av} + {1'b0, ~bv} + 17'd1;
        else    e = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_run", 32'(in_ready), 32'd0);
        check("busy_run", 32'(busy), 32'd1);
        if (inject) begin
            a = ~av; b = 16'h1357; cin = ~cv; sub_i = 1'b0; in_valid = 1'b1;
        end
    endtask

    // Wait for the result, compare against the queue, then hand it off.
    task automatic receive(input int hold);
        int n;
        logic [W:0] e;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end
        check("latency_edges", 32'(n), 32'(NS));
        check("out_valid_rise", 32'(out_valid), 32'd1);
        if (!out_valid) begin
            exp_q.delete();
            return;
        end
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = 16'($urandom_range(0, 16'hFFFF));
            b = 16'($urandom_range(0, 16'hFFFF));
            @(posedge clk);
            @(negedge clk);
            check("hold_sum", 32'(sum), 32'(e[W-1:0]));
            check("hold_cout", 32'(cout), 32'(e[W]));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Full carry ripple across every nibble
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        receive(0);

        send(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
        receive(0);

        // Backpressure with in_valid pulses while DONE
        send(16'hBEEF, 16'h1111, 1'b0, 1'b0, 1'b0);
        receive(6);

        // New request during RUN must be ignored
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1);
        receive(0);

        // Reset while slice 2 is being computed
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;

        send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        receive(0);

        for (int i = 0; i < 4; i++) begin
            send(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            receive(i % 2);
        end

`ifdef SEQ_CLA_ADD_CTRL_SUB_EN
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        receive(0);
        send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
        receive(0);
        sub_i = 1'b0;
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
